count_stream_checker: RTL and testbench

- Receive-side monitor for the 8-bit free-running counter bus driven onto uo_out, together with the enable bit that drives that counter.
- Registers each sample and predicts the next value as previous count plus previous enable, modulo 2^WIDTH.
- Locks after SYNC_LEN consecutive correct samples, then flags and counts any break in sequence and counts clean wrap-arounds.
- Sits at the consumer end of the counter interface: in the test harness, or on a second tile reading the first tile's outputs.

---
 rtl/count_stream_checker.sv | 135 +++++++++++++
 tb/tb_count_stream_checker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/count_stream_checker.sv
// Receive-side monitor for a free-running counter bus: predicts each sample from the
// previous count and enable, locks after SYNC_LEN clean samples, then counts breaks and wraps.
module count_stream_checker #(
  parameter int WIDTH    = 8,
  parameter int SYNC_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       wrap_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HUNT   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [3:0]         match_cnt_r;
  logic [3:0]         match_cnt_s;
  logic [WIDTH-1:0]   prev_count_r;
  logic               prev_en_r;
  logic               locked_r;
  logic               err_pulse_r;
  logic               err_pulse_s;
  logic [ERR_W-1:0]   err_count_r;
  logic [ERR_W-1:0]   err_count_s;
  logic [7:0]         wrap_count_r;
  logic [7:0]         wrap_count_s;
  logic [WIDTH-1:0]   exp_s;
  logic               match_s;
  logic               wrap_s;
  logic [4:0]         match_inc_s;

  // Prediction, match detection and FSM next-state / statistics update.
  always_comb begin
    exp_s        = prev_count_r + {{(WIDTH-1){1'b0}}, prev_en_r};
    match_s      = (count_in == exp_s);
    wrap_s       = match_s && prev_en_r && (prev_count_r == {WIDTH{1'b1}})
                   && (count_in == {WIDTH{1'b0}});
    match_inc_s  = {1'b0, match_cnt_r} + 5'd1;
    state_s      = state_r;
    match_cnt_s  = match_cnt_r;
    err_pulse_s  = 1'b0;
    err_count_s  = err_count_r;
    wrap_count_s = wrap_count_r;
    if (clear) begin
      // Clear wins over any simultaneous break or wrap.
      state_s      = IDLE;
      match_cnt_s  = 4'd0;
      err_count_s  = {ERR_W{1'b0}};
      wrap_count_s = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s     = HUNT;
          match_cnt_s = 4'd0;
        end
        HUNT: begin
          if (match_s) begin
            if (match_inc_s == 5'(SYNC_LEN)) begin
              state_s     = LOCKED;
              match_cnt_s = 4'd0;
            end else begin
              match_cnt_s = match_inc_s[3:0];
            end
          end else begin
            match_cnt_s = 4'd0;
          end
        end
        LOCKED: begin
          if (match_s) begin
            if (wrap_s) begin
              wrap_count_s = wrap_count_r + 8'd1;
            end else begin
              wrap_count_s = wrap_count_r;
            end
          end else begin
            err_pulse_s = 1'b1;
            state_s     = HUNT;
            match_cnt_s = 4'd0;
            if (err_count_r != {ERR_W{1'b1}}) begin
              err_count_s = err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
              err_count_s = err_count_r;
            end
          end
        end
        default: begin
          state_s     = IDLE;
          match_cnt_s = 4'd0;
        end
      endcase
    end
  end

  // State, sample history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      match_cnt_r  <= 4'd0;
      prev_count_r <= {WIDTH{1'b0}};
      prev_en_r    <= 1'b0;
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_count_r  <= {ERR_W{1'b0}};
      wrap_count_r <= 8'd0;
    end else begin
      state_r      <= state_s;
      match_cnt_r  <= match_cnt_s;
      prev_count_r <= count_in;
      prev_en_r    <= enable;
      locked_r     <= (state_s == LOCKED);
      err_pulse_r  <= err_pulse_s;
      err_count_r  <= err_count_s;
      wrap_count_r <= wrap_count_s;
    end
  end

  assign locked     = locked_r;
  assign err_pulse  = err_pulse_r;
  assign err_count  = err_count_r;
  assign wrap_count = wrap_count_r;
  assign state      = state_r;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker: lock-in, wrap, break, hold, clear priority,
// error saturation and asynchronous reset.
module tb_count_stream_checker;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] count_in;
  logic       clear;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] wrap_count;
  logic [1:0] state;

  int checks;
  int errors;

  count_stream_checker #(.WIDTH(8), .SYNC_LEN(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .count_in(count_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_count(wrap_count), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample, let the next rising edge take it, then settle.
  task automatic step(input logic [7:0] c, input logic e, input logic clr);
    count_in = c;
    enable   = e;
    clear    = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] bad;
    int         exp_err;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; clear = 1'b0; enable = 1'b0; count_in = 8'd0;
    #12;
    chk("rst_state", state, 2'b00);
    chk("rst_locked", locked, 1'b0);
    chk("rst_err", err_count, 8'd0);
    chk("rst_wrap", wrap_count, 8'd0);
    chk("rst_pulse", err_pulse, 1'b0);
    rst_n = 1'b1;

    // Lock-in
    step(8'd0, 1'b1, 1'b0);
    chk("lock_hunt", state, 2'b01);
    step(8'd1, 1'b1, 1'b0);
    step(8'd2, 1'b1, 1'b0);
    step(8'd3, 1'b1, 1'b0);
    chk("lock_still_hunt", state, 2'b01);
    chk("lock_not_yet", locked, 1'b0);
    step(8'd4, 1'b1, 1'b0);
    chk("lock_state", state, 2'b10);
    chk("lock_locked", locked, 1'b1);
    step(8'd5, 1'b1, 1'b0);
    chk("lock_hold", locked, 1'b1);
    chk("lock_err", err_count, 8'd0);

    // Wrap: clear, relock at 253, then cross 255 -> 0
    step(8'd248, 1'b1, 1'b1);
    chk("clr_idle", state, 2'b00);
    chk("clr_unlocked", locked, 1'b0);
    step(8'd249, 1'b1, 1'b0);
    for (int i = 250; i <= 253; i++) step(8'(i), 1'b1, 1'b0);
    chk("wrap_locked", locked, 1'b1);
    step(8'd254, 1'b1, 1'b0);
    step(8'd255, 1'b1, 1'b0);
    chk("wrap_pre", wrap_count, 8'd0);
    step(8'd0, 1'b1, 1'b0);
    chk("wrap_count", wrap_count, 8'd1);
    chk("wrap_pulse", err_pulse, 1'b0);
    step(8'd1, 1'b1, 1'b0);
    chk("wrap_locked2", locked, 1'b1);
    chk("wrap_count2", wrap_count, 8'd1);

    // Break at 13 after 10,11
    for (int i = 2; i <= 11; i++) step(8'(i), 1'b1, 1'b0);
    chk("brk_pre_pulse", err_pulse, 1'b0);
    step(8'd13, 1'b1, 1'b0);
    chk("brk_pulse", err_pulse, 1'b1);
    chk("brk_err", err_count, 8'd1);
    chk("brk_state", state, 2'b01);
    chk("brk_locked", locked, 1'b0);
    step(8'd14, 1'b1, 1'b0);
    chk("brk_pulse_once", err_pulse, 1'b0);
    chk("brk_hunt", state, 2'b01);
    step(8'd15, 1'b1, 1'b0);
    step(8'd16, 1'b1, 1'b0);
    step(8'd17, 1'b1, 1'b0);
    chk("brk_relock", locked, 1'b1);
    chk("brk_err_kept", err_count, 8'd1);

    // Hold at 42 with enable low
    for (int i = 18; i <= 41; i++) step(8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(8'd42, 1'b0, 1'b0);
    chk("hold_state", state, 2'b10);
    chk("hold_pulse", err_pulse, 1'b0);
    chk("hold_err", err_count, 8'd1);
    step(8'd43, 1'b0, 1'b0);
    chk("hold_brk_pulse", err_pulse, 1'b1);
    chk("hold_brk_err", err_count, 8'd2);

    // Bring err_count to 3, relock, then clear against a mismatch
    for (int i = 43; i <= 46; i++) step(8'(i), 1'b1, 1'b0);
    chk("cp_lock1", locked, 1'b1);
    step(8'd50, 1'b1, 1'b0);
    chk("cp_err3", err_count, 8'd3);
    for (int i = 51; i <= 54; i++) step(8'(i), 1'b1, 1'b0);
    chk("cp_lock2", locked, 1'b1);
    step(8'd60, 1'b1, 1'b1);
    chk("cp_err", err_count, 8'd0);
    chk("cp_pulse", err_pulse, 1'b0);
    chk("cp_state", state, 2'b00);
    chk("cp_wrap", wrap_count, 8'd0);

    // Saturation: 260 lock/break cycles
    step(8'd61, 1'b1, 1'b0);
    v = 8'd61;
    for (int i = 0; i < 260; i++) begin
      for (int k = 1; k <= 4; k++) step(v + 8'(k), 1'b1, 1'b0);
      bad = v + 8'd6;
      step(bad, 1'b1, 1'b0);
      exp_err = (i + 1 > 255) ? 255 : i + 1;
      chk("sat_pulse", err_pulse, 1'b1);
      chk("sat_err", err_count, 32'(exp_err));
      v = bad;
    end
    chk("sat_final", err_count, 8'd255);
    chk("sat_wrap", wrap_count, 8'd0);

    // Asynchronous reset between edges
    for (int k = 1; k <= 4; k++) step(v + 8'(k), 1'b1, 1'b0);
    chk("ar_locked_pre", locked, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_state", state, 2'b00);
    chk("ar_locked", locked, 1'b0);
    chk("ar_err", err_count, 8'd0);
    chk("ar_wrap", wrap_count, 8'd0);
    chk("ar_pulse", err_pulse, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
